// File: rtl/n101_uart_txq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : n101_uart_txq_if
// Description : Byte-wide ready/valid handshake bundle used on both sides of
//               the UART transmit queue. The master drives valid/bits and the
//               slave drives ready.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface n101_uart_txq_if #(
  parameter int DW = 8
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] bits;

  modport master (
    output valid,
    output bits,
    input  ready
  );

  modport slave (
    input  valid,
    input  bits,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/n101_uart_txq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : n101_uart_txq
// Description : UART transmit FIFO. Accepts bytes from the register interface
//               on the enq port and presents them first-word-fall-through to
//               the transmitter on the deq port. Produces the fill level,
//               full/empty flags and the TX watermark interrupt.
//               Optional feature macro: N101_UART_TXQ_OVF_EN enables a sticky
//               overflow flag on ovf; when undefined ovf is tied low.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module n101_uart_txq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  wire             clock,
  input  wire             reset,
  input  wire             clear,
  n101_uart_txq_if.slave  enq,
  n101_uart_txq_if.master deq,
  input  wire [AW-1:0]    txcnt,
  output logic [AW:0]     count,
  output logic            full,
  output logic            empty,
  output logic            txwm_ip,
  output logic            ovf
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ZERO  = '0;

  // Storage and pointers. Storage is deliberately not reset.
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Handshake qualifiers.
  logic w_full;
  logic w_empty;
  logic w_do_enq;
  logic w_do_deq;
  logic w_ovf_attempt;
  logic [AW:0] w_count_nxt;

  assign w_full        = (r_count == C_DEPTH);
  assign w_empty       = (r_count == C_ZERO);
  // A full queue never accepts, even if the transmitter drains this cycle.
  assign w_do_enq      = enq.valid && !w_full;
  assign w_do_deq      = deq.ready && !w_empty;
  assign w_ovf_attempt = enq.valid && w_full;

  assign enq.ready = !w_full;
  assign deq.valid = !w_empty;
  assign deq.bits  = r_mem[r_rptr];

  assign count   = r_count;
  assign full    = w_full;
  assign empty   = w_empty;
  assign txwm_ip = (r_count < {1'b0, txcnt});

  // Next fill level from the enqueue/dequeue combination.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_enq, w_do_deq})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Byte storage write; a clear in the same cycle discards the byte.
  always_ff @(posedge clock) begin
    if (w_do_enq && !clear) begin
      r_mem[r_wptr] <= enq.bits;
    end
  end

  // Pointer and fill-level registers; clear outranks enqueue/dequeue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_enq) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_deq) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
    end
  end

`ifdef N101_UART_TXQ_OVF_EN
  logic r_ovf;

  // Sticky overflow flag, set by a write attempt on a full queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (clear) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_attempt) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf_attempt;
  assign ovf          = 1'b0;
`endif

endmodule
`default_nettype wire
